// File: rtl/truth_table_checker_if.sv
// Harness-side bundle for truth_table_checker: run control, DUT stimulus/response and results.
// With CHK_MISR_EN defined the bundle also carries the 16-bit response signature.
interface truth_table_checker_if #(
  parameter int N_IN = 4
);
  logic               start;
  logic [N_IN-1:0]    vec;
  logic               f_in;
  logic               busy;
  logic               done;
  logic               pass;
  logic [2**N_IN-1:0] captured;
  logic [N_IN:0]      err_count;
  logic [N_IN-1:0]    first_fail;
  logic               fail_valid;
`ifdef CHK_MISR_EN
  logic [15:0]        sig;

  modport master (
    output start, f_in,
    input  vec, busy, done, pass, captured, err_count, first_fail, fail_valid, sig
  );
  modport slave (
    input  start, f_in,
    output vec, busy, done, pass, captured, err_count, first_fail, fail_valid, sig
  );
`else
  modport master (
    output start, f_in,
    input  vec, busy, done, pass, captured, err_count, first_fail, fail_valid
  );
  modport slave (
    input  start, f_in,
    output vec, busy, done, pass, captured, err_count, first_fail, fail_valid
  );
`endif
endinterface

// File: rtl/truth_table_checker.sv
// Exhaustive response checker: walks vec over all 2**N_IN inputs, samples f_in SETTLE edges later,
// and compares the captured table with EXPECTED. Define CHK_MISR_EN to add a CRC-16-CCITT signature (sig).
module truth_table_checker #(
  parameter int                 N_IN     = 4,
  parameter logic [2**N_IN-1:0] EXPECTED = '0,
  parameter int                 SETTLE   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  truth_table_checker_if.slave bus
);
  localparam int              NV       = 2**N_IN;
  localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [NV-1:0]   cap_q, cap_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            fv_q, fv_d;
`ifdef CHK_MISR_EN
  logic [15:0]     sig_q, sig_d;
`endif

  logic            mism;
  logic [N_IN:0]   err_inc;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    cap_d   = cap_q;
    err_d   = err_q;
    ff_d    = ff_q;
    fv_d    = fv_q;
`ifdef CHK_MISR_EN
    sig_d   = sig_q;
`endif
    mism    = (bus.f_in != EXPECTED[vec_q]);
    // err_count can reach 2**N_IN at most, so the N_IN+1 bit sum never wraps
    err_inc = err_q + {{N_IN{1'b0}}, mism};

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          vec_d   = '0;
          cap_d   = '0;
          err_d   = '0;
          ff_d    = '0;
          fv_d    = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = (SETTLE == 1) ? S_SAMPLE : S_SETTLE;
`ifdef CHK_MISR_EN
          sig_d   = 16'hFFFF;
`endif
        end
      end
      S_SETTLE: begin
        // leaving on the edge that sees 1 puts the sample exactly SETTLE edges after vec changed
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_SAMPLE: begin
        cap_d[vec_q] = bus.f_in;
        err_d        = err_inc;
        if (mism && !fv_q) begin
          ff_d = vec_q;
          fv_d = 1'b1;
        end
`ifdef CHK_MISR_EN
        sig_d = {sig_q[14:0], 1'b0} ^ ((sig_q[15] ^ bus.f_in) ? 16'h1021 : 16'h0000);
`endif
        if (vec_q != VEC_LAST) begin
          vec_d   = vec_q + N_IN'(1);
          cnt_d   = CNT_INIT;
          state_d = (SETTLE == 1) ? S_SAMPLE : S_SETTLE;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_inc == '0);
          vec_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      cap_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      fv_q    <= 1'b0;
`ifdef CHK_MISR_EN
      sig_q   <= 16'hFFFF;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      cap_q   <= cap_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      fv_q    <= fv_d;
`ifdef CHK_MISR_EN
      sig_q   <= sig_d;
`endif
    end
  end

  assign bus.vec        = vec_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.captured   = cap_q;
  assign bus.err_count  = err_q;
  assign bus.first_fail = ff_q;
  assign bus.fail_valid = fv_q;
`ifdef CHK_MISR_EN
  assign bus.sig        = sig_q;
`endif
endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: three instances (SETTLE 1/3/2) fed by a bench-side truth table
// whose f_in is only correct on the exact sampling edge; results are checked against a table model.
module tb_truth_table_checker;
  localparam int          NI       = 3;
  localparam logic [15:0] EXP[NI]  = '{16'h8000, 16'h8000, 16'h0000};
  localparam int          STL[NI]  = '{1, 3, 2};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_r[NI];
  logic        f_r[NI];
  logic [15:0] tt[NI];
  logic        busy_w[NI], done_w[NI], pass_w[NI], fv_w[NI];
  logic [3:0]  vec_w[NI], ff_w[NI];
  logic [15:0] cap_w[NI];
  logic [4:0]  err_w[NI];
`ifdef CHK_MISR_EN
  logic [15:0] sig_w[NI];
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  truth_table_checker_if #(.N_IN(4)) tif[NI] ();

  for (genvar g = 0; g < NI; g++) begin : g_dut
    truth_table_checker #(.N_IN(4), .EXPECTED(EXP[g]), .SETTLE(STL[g])) u_dut (
      .clk(clk), .rst(rst), .bus(tif[g])
    );
    assign tif[g].start = start_r[g];
    assign tif[g].f_in  = f_r[g];
    assign busy_w[g]    = tif[g].busy;
    assign done_w[g]    = tif[g].done;
    assign pass_w[g]    = tif[g].pass;
    assign fv_w[g]      = tif[g].fail_valid;
    assign vec_w[g]     = tif[g].vec;
    assign ff_w[g]      = tif[g].first_fail;
    assign cap_w[g]     = tif[g].captured;
    assign err_w[g]     = tif[g].err_count;
`ifdef CHK_MISR_EN
    assign sig_w[g]     = tif[g].sig;
`endif
  end

  // Harness DUT: f_in shows tt[vec] only on the edge SETTLE after vec changed, inverted otherwise,
  // so any sample taken on the wrong edge lands the wrong bit in captured.
  int         age[NI];
  logic [3:0] pvec[NI];
  logic       pbusy[NI];
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (vec_w[i] !== pvec[i] || (busy_w[i] === 1'b1 && pbusy[i] !== 1'b1)) age[i] = 0;
      else age[i] = age[i] + 1;
      pvec[i]  = vec_w[i];
      pbusy[i] = busy_w[i];
      f_r[i]   = (age[i] == STL[i] - 1) ? tt[i][vec_w[i]] : ~tt[i][vec_w[i]];
    end
  end

  function automatic void model(input int id, input logic [15:0] t, output logic [4:0] e,
                                output logic [3:0] ff, output logic fv, output logic p);
    logic [15:0] diff;
    diff = t ^ EXP[id];
    e = '0; ff = '0; fv = 1'b0;
    for (int v = 0; v < 16; v++) begin
      if (diff[v]) begin
        e = e + 5'd1;
        if (!fv) begin fv = 1'b1; ff = 4'(v); end
      end
    end
    p = (e == 5'd0);
  endfunction

  function automatic logic [15:0] crc_model(input logic [15:0] t);
    logic [15:0] s;
    s = 16'hFFFF;
    for (int v = 0; v < 16; v++) begin
      if (s[15] ^ t[v]) s = (s << 1) ^ 16'h1021;
      else s = s << 1;
    end
    return s;
  endfunction

  task automatic pulse_start(input int id);
    @(negedge clk); start_r[id] = 1'b1;
    @(negedge clk); start_r[id] = 1'b0;
  endtask

  task automatic wait_done(input int id, output int cyc);
    cyc = 0;
    while (cyc < 400) begin
      @(negedge clk); cyc++;
      if (done_w[id] === 1'b1) return;
    end
    cyc = -1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NI; i++) begin start_r[i] = 1'b0; tt[i] = '0; end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if ({busy_w[i], done_w[i], pass_w[i], fv_w[i], vec_w[i], ff_w[i], cap_w[i], err_w[i]} !== '0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got busy=%b done=%b pass=%b fv=%b vec=%h ff=%h cap=%h err=%0d want all zero",
                 i, busy_w[i], done_w[i], pass_w[i], fv_w[i], vec_w[i], ff_w[i], cap_w[i], err_w[i]);
      end
`ifdef CHK_MISR_EN
      n_cmp++;
      if (sig_w[i] !== 16'hFFFF) begin n_fail++; $display("FAIL reset_sig[%0d]: got %h want ffff", i, sig_w[i]); end
`endif
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_and4();
    tt[0] = 16'h8000;
    pulse_start(0);
    n_cmp++;
    if (busy_w[0] !== 1'b1 || vec_w[0] !== 4'd0) begin
      n_fail++; $display("FAIL and4_start: got busy=%b vec=%h want busy=1 vec=0", busy_w[0], vec_w[0]);
    end
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      n_cmp++;
      if (vec_w[0] !== 4'(k) || done_w[0] !== 1'b0) begin
        n_fail++; $display("FAIL and4_step%0d: got vec=%h done=%b want vec=%h done=0", k, vec_w[0], done_w[0], 4'(k));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || vec_w[0] !== 4'd0) begin
      n_fail++; $display("FAIL and4_done16: got done=%b busy=%b vec=%h want 1 0 0", done_w[0], busy_w[0], vec_w[0]);
    end
    n_cmp++;
    if ({pass_w[0], cap_w[0], err_w[0], fv_w[0]} !== {1'b1, 16'h8000, 5'd0, 1'b0}) begin
      n_fail++; $display("FAIL and4_result: got pass=%b cap=%h err=%0d fv=%b want 1 8000 0 0",
                         pass_w[0], cap_w[0], err_w[0], fv_w[0]);
    end
    @(negedge clk);
    n_cmp++;
    if (done_w[0] !== 1'b0 || pass_w[0] !== 1'b1 || cap_w[0] !== 16'h8000) begin
      n_fail++; $display("FAIL and4_hold: got done=%b pass=%b cap=%h want 0 1 8000", done_w[0], pass_w[0], cap_w[0]);
    end
  endtask

  task automatic test_all_ones();
    int cyc;
    tt[2] = 16'hFFFF;
    pulse_start(2);
    wait_done(2, cyc);
    n_cmp++;
    if (cyc != 32) begin n_fail++; $display("FAIL ones_latency: got %0d want 32", cyc); end
    n_cmp++;
    if ({err_w[2], ff_w[2], fv_w[2], pass_w[2], cap_w[2]} !== {5'd16, 4'd0, 1'b1, 1'b0, 16'hFFFF}) begin
      n_fail++; $display("FAIL ones_result: got err=%0d ff=%h fv=%b pass=%b cap=%h want 16 0 1 0 ffff",
                         err_w[2], ff_w[2], fv_w[2], pass_w[2], cap_w[2]);
    end
  endtask

  task automatic test_settle3();
    int cyc, last;
    logic [3:0] pv;
    tt[1] = 16'h8020;
    pulse_start(1);
    cyc = 0; last = 0; pv = 4'd0;
    while (cyc < 200 && done_w[1] !== 1'b1) begin
      @(negedge clk); cyc++;
      if (vec_w[1] !== pv && done_w[1] !== 1'b1) begin
        n_cmp++;
        if (cyc - last != 3) begin n_fail++; $display("FAIL settle_period: got %0d want 3 at vec=%h", cyc - last, vec_w[1]); end
        last = cyc; pv = vec_w[1];
      end
    end
    n_cmp++;
    if (cyc != 48 || done_w[1] !== 1'b1) begin n_fail++; $display("FAIL settle_latency: got %0d want 48", cyc); end
    n_cmp++;
    if ({err_w[1], ff_w[1], fv_w[1], pass_w[1], cap_w[1]} !== {5'd1, 4'd5, 1'b1, 1'b0, 16'h8020}) begin
      n_fail++; $display("FAIL settle_result: got err=%0d ff=%h fv=%b pass=%b cap=%h want 1 5 1 0 8020",
                         err_w[1], ff_w[1], fv_w[1], pass_w[1], cap_w[1]);
    end
  endtask

  task automatic test_start_busy();
    int cyc, extra;
    logic [4:0] e; logic [3:0] ff; logic fv, p;
    tt[0] = 16'hFFFF;
    pulse_start(0);
    cyc = 0;
    while (cyc < 200 && done_w[0] !== 1'b1) begin
      @(negedge clk); cyc++;
      start_r[0] = (cyc == 5);
    end
    start_r[0] = 1'b0;
    n_cmp++;
    if (cyc != 16) begin n_fail++; $display("FAIL busy_ignore_latency: got %0d want 16", cyc); end
    extra = 0;
    repeat (40) begin @(negedge clk); if (done_w[0] === 1'b1 || busy_w[0] === 1'b1) extra++; end
    n_cmp++;
    if (extra != 0) begin n_fail++; $display("FAIL busy_ignore_extra: got %0d busy/done cycles want 0", extra); end
    // restart on the done cycle
    pulse_start(0);
    wait_done(0, cyc);
    tt[0] = 16'($urandom);
    start_r[0] = 1'b1;
    @(negedge clk); start_r[0] = 1'b0;
    n_cmp++;
    if ({busy_w[0], done_w[0], vec_w[0], err_w[0], cap_w[0], fv_w[0], pass_w[0]} !== {1'b1, 1'b0, 4'd0, 5'd0, 16'h0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL restart_clear: got busy=%b done=%b vec=%h err=%0d cap=%h fv=%b pass=%b want 1 0 0 0 0 0 0",
                         busy_w[0], done_w[0], vec_w[0], err_w[0], cap_w[0], fv_w[0], pass_w[0]);
    end
    wait_done(0, cyc);
    model(0, tt[0], e, ff, fv, p);
    n_cmp++;
    if (cyc != 16 || {err_w[0], ff_w[0], fv_w[0], pass_w[0], cap_w[0]} !== {e, ff, fv, p, tt[0]}) begin
      n_fail++; $display("FAIL restart_result: got cyc=%0d err=%0d ff=%h fv=%b pass=%b cap=%h want 16 %0d %h %b %b %h",
                         cyc, err_w[0], ff_w[0], fv_w[0], pass_w[0], cap_w[0], e, ff, fv, p, tt[0]);
    end
  endtask

  task automatic test_rst_abort();
    int cyc, dn;
    logic [4:0] e; logic [3:0] ff; logic fv, p;
    tt[0] = 16'h7FFF;
    pulse_start(0);
    cyc = 0;
    while (cyc < 100 && vec_w[0] !== 4'd7) begin @(negedge clk); cyc++; end
    n_cmp++;
    if (vec_w[0] !== 4'd7 || err_w[0] !== 5'd7) begin
      n_fail++; $display("FAIL abort_pre: got vec=%h err=%0d want 7 7", vec_w[0], err_w[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy_w[0], done_w[0], vec_w[0], err_w[0], cap_w[0], fv_w[0], pass_w[0]} !== '0) begin
      n_fail++; $display("FAIL abort_clear: got busy=%b done=%b vec=%h err=%0d cap=%h fv=%b pass=%b want all zero",
                         busy_w[0], done_w[0], vec_w[0], err_w[0], cap_w[0], fv_w[0], pass_w[0]);
    end
    dn = 0;
    repeat (30) begin @(negedge clk); if (done_w[0] === 1'b1 || busy_w[0] === 1'b1) dn++; end
    n_cmp++;
    if (dn != 0) begin n_fail++; $display("FAIL abort_nodone: got %0d busy/done cycles want 0", dn); end
    tt[0] = 16'($urandom);
    pulse_start(0);
    wait_done(0, cyc);
    model(0, tt[0], e, ff, fv, p);
    n_cmp++;
    if (cyc != 16 || {err_w[0], ff_w[0], fv_w[0], pass_w[0], cap_w[0]} !== {e, ff, fv, p, tt[0]}) begin
      n_fail++; $display("FAIL abort_rerun: got cyc=%0d err=%0d ff=%h fv=%b pass=%b cap=%h want 16 %0d %h %b %b %h",
                         cyc, err_w[0], ff_w[0], fv_w[0], pass_w[0], cap_w[0], e, ff, fv, p, tt[0]);
    end
  endtask

  task automatic test_random();
    int cyc, id;
    logic [4:0] e; logic [3:0] ff; logic fv, p;
    for (int it = 0; it < 12; it++) begin
      id = it % NI;
      case (it)
        3:       tt[id] = EXP[id];
        4:       tt[id] = ~EXP[id];
        default: tt[id] = 16'($urandom);
      endcase
      pulse_start(id);
      wait_done(id, cyc);
      model(id, tt[id], e, ff, fv, p);
      n_cmp++;
      if (cyc != 16 * STL[id] || {err_w[id], ff_w[id], fv_w[id], pass_w[id], cap_w[id]} !== {e, ff, fv, p, tt[id]}) begin
        n_fail++; $display("FAIL random%0d[%0d]: got cyc=%0d err=%0d ff=%h fv=%b pass=%b cap=%h want %0d %0d %h %b %b %h",
                           it, id, cyc, err_w[id], ff_w[id], fv_w[id], pass_w[id], cap_w[id], 16 * STL[id], e, ff, fv, p, tt[id]);
      end
`ifdef CHK_MISR_EN
      n_cmp++;
      if (sig_w[id] !== crc_model(tt[id])) begin
        n_fail++; $display("FAIL random_sig%0d: got %h want %h", it, sig_w[id], crc_model(tt[id]));
      end
`endif
    end
  endtask

`ifdef CHK_MISR_EN
  task automatic test_misr();
    int cyc;
    tt[0] = 16'h0000;
    pulse_start(0);
    n_cmp++;
    if (sig_w[0] !== 16'hFFFF) begin n_fail++; $display("FAIL misr_init: got %h want ffff", sig_w[0]); end
    wait_done(0, cyc);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sig_w[0] !== crc_model(16'h0000)) begin
      n_fail++; $display("FAIL misr_zero: got %h want %h", sig_w[0], crc_model(16'h0000));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_and4();
    test_all_ones();
    test_settle3();
    test_start_busy();
    test_rst_abort();
    test_random();
`ifdef CHK_MISR_EN
    test_misr();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
